// File: rtl/dcls_lockstep_ctrl.sv
// Lockstep checker/sequencer for the dual-core lockstep pair: aligns the main
// core bundle with the shadow core, compares every cycle and escalates to FAULT.
module dcls_lockstep_ctrl #(
  parameter int unsigned DCLS_DELAY   = 2,
  parameter int unsigned CMP_W        = 64,
  parameter int unsigned FAULT_THRESH = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic [CMP_W-1:0] main_bus_i,
  input  logic [CMP_W-1:0] shadow_bus_i,
  output logic [CMP_W-1:0] main_bus_dly_o,
  output logic             armed_o,
  output logic             mismatch_o,
  output logic             fault_o,
  output logic [CMP_W-1:0] syndrome_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    CHECK  = 2'd2,
    FAULT  = 2'd3
  } state_e;

  localparam logic [3:0]       WARM_LAST = 4'(DCLS_DELAY - 1);
  localparam logic [3:0]       THRESH    = 4'(FAULT_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [CMP_W-1:0] dly_q [DCLS_DELAY];

  state_e           state_q, state_d;
  logic [3:0]       warm_q, warm_d;
  logic [3:0]       consec_q, consec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CMP_W-1:0] syn_q, syn_d;
  logic             syn_valid_q, syn_valid_d;
  logic             mismatch_q, mismatch_d;
  logic             armed_q, fault_q;
  logic             miss;

  // Main-core delay line; shifts in every state so alignment never slips.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DCLS_DELAY); i++) begin
        dly_q[i] <= '0;
      end
    end else begin
      dly_q[0] <= main_bus_i;
      for (int i = 1; i < int'(DCLS_DELAY); i++) begin
        dly_q[i] <= dly_q[i-1];
      end
    end
  end

  assign main_bus_dly_o = dly_q[DCLS_DELAY-1];
  assign miss           = (main_bus_dly_o != shadow_bus_i);

  always_comb begin
    state_d     = state_q;
    warm_d      = warm_q;
    consec_d    = consec_q;
    err_d       = err_q;
    syn_d       = syn_q;
    syn_valid_d = syn_valid_q;
    mismatch_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = WARMUP;
          warm_d  = 4'd0;
        end
      end

      WARMUP: begin
        warm_d = warm_q + 4'd1;
        if (!enable_i) begin
          state_d = IDLE;
        end else if (warm_q == WARM_LAST) begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (miss) begin
          mismatch_d = 1'b1;
          consec_d   = consec_q + 4'd1;
          if (err_q != CNT_MAX) begin
            err_d = err_q + 1'b1;
          end
          if (!syn_valid_q && (syn_q == '0)) begin
            syn_d       = main_bus_dly_o ^ shadow_bus_i;
            syn_valid_d = 1'b1;
          end
          if ((consec_q + 4'd1) == THRESH) begin
            state_d = FAULT;
          end
        end else begin
          consec_d = 4'd0;
        end
        // Reaching the threshold wins over a falling enable.
        if ((state_d != FAULT) && !enable_i) begin
          state_d  = IDLE;
          consec_d = 4'd0;
        end
      end

      FAULT: begin
        if (clear_i) begin
          state_d     = WARMUP;
          warm_d      = 4'd0;
          consec_d    = 4'd0;
          syn_d       = '0;
          syn_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      warm_q      <= 4'd0;
      consec_q    <= 4'd0;
      err_q       <= '0;
      syn_q       <= '0;
      syn_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      armed_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      warm_q      <= warm_d;
      consec_q    <= consec_d;
      err_q       <= err_d;
      syn_q       <= syn_d;
      syn_valid_q <= syn_valid_d;
      mismatch_q  <= mismatch_d;
      armed_q     <= (state_d == CHECK);
      fault_q     <= (state_d == FAULT);
    end
  end

  assign armed_o    = armed_q;
  assign mismatch_o = mismatch_q;
  assign fault_o    = fault_q;
  assign syndrome_o = syn_q;
  assign err_cnt_o  = err_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_dcls_lockstep_ctrl.sv
// Self-checking bench for dcls_lockstep_ctrl: default instance plus a narrow
// counter instance for saturation; delay and error-count scoreboards.
module tb_dcls_lockstep_ctrl;

  localparam int D = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, clear;
  logic [63:0] main_bus, shadow_bus;
  logic [63:0] dly, syn;
  logic        armed, mis, fault;
  logic [15:0] err;
  logic [1:0]  state;

  logic        s_rst_n, s_enable, s_clear;
  logic [63:0] s_main, s_shadow;
  logic [63:0] s_dly, s_syn;
  logic        s_armed, s_mis, s_fault;
  logic [3:0]  s_err;
  logic [1:0]  s_state;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_dly_q [$];
  logic [3:0]  exp_err_q [$];

  dcls_lockstep_ctrl #(.DCLS_DELAY(D), .CMP_W(64), .FAULT_THRESH(2), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear),
    .main_bus_i(main_bus), .shadow_bus_i(shadow_bus), .main_bus_dly_o(dly),
    .armed_o(armed), .mismatch_o(mis), .fault_o(fault), .syndrome_o(syn),
    .err_cnt_o(err), .state_o(state)
  );

  dcls_lockstep_ctrl #(.DCLS_DELAY(D), .CMP_W(64), .FAULT_THRESH(15), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_ni(s_rst_n), .enable_i(s_enable), .clear_i(s_clear),
    .main_bus_i(s_main), .shadow_bus_i(s_shadow), .main_bus_dly_o(s_dly),
    .armed_o(s_armed), .mismatch_o(s_mis), .fault_o(s_fault), .syndrome_o(s_syn),
    .err_cnt_o(s_err), .state_o(s_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shadow is driven as the bench's own record of main from D cycles ago, XOR inj.
  task automatic step(input logic [63:0] m, input logic [63:0] inj);
    main_bus   = m;
    shadow_bus = exp_dly_q[0] ^ inj;
    exp_dly_q.push_back(m);
    tick();
    void'(exp_dly_q.pop_front());
  endtask

  task automatic flush_model();
    exp_dly_q.delete();
    for (int i = 0; i < D; i++) exp_dly_q.push_back(64'd0);
  endtask

  task automatic bring_up();
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; main_bus = '0; shadow_bus = '0;
    tick();
    rst_n = 1'b1;
    flush_model();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) step(64'd0, 64'd0);
  endtask

  task automatic test_reset();
    main_bus = '1;
    tick(); tick();
    checks++; if (dly !== 64'd0) begin failures++; $display("[TB] FAIL rst_dly got=%h exp=0", dly); end
    checks++; if (state !== 2'd0) begin failures++; $display("[TB] FAIL rst_state got=%0d exp=0", state); end
    checks++; if ({armed, mis, fault} !== 3'b000) begin failures++; $display("[TB] FAIL rst_flags got=%b exp=000", {armed, mis, fault}); end
    checks++; if (syn !== 64'd0) begin failures++; $display("[TB] FAIL rst_syn got=%h exp=0", syn); end
    checks++; if (err !== 16'd0) begin failures++; $display("[TB] FAIL rst_err got=%0d exp=0", err); end
    rst_n = 1'b1;
    flush_model();
    step(64'd0, 64'd0);
    checks++; if (state !== 2'd0) begin failures++; $display("[TB] FAIL idle_hold got=%0d exp=0", state); end
  endtask

  task automatic test_warmup();
    logic [63:0] m_tab [3];
    logic [63:0] i_tab [3];
    logic [1:0]  s_tab [3];
    m_tab = '{64'h5A, 64'h00, 64'h00};
    i_tab = '{64'hC3, 64'hC3, 64'h99};
    s_tab = '{2'd1, 2'd1, 2'd2};
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(m_tab[i], i_tab[i]);
      checks++; if (state !== s_tab[i]) begin failures++; $display("[TB] FAIL warm_state[%0d] got=%0d exp=%0d", i, state, s_tab[i]); end
      checks++; if (mis !== 1'b0) begin failures++; $display("[TB] FAIL warm_mis[%0d] got=%b exp=0", i, mis); end
      checks++; if (armed !== (s_tab[i] == 2'd2)) begin failures++; $display("[TB] FAIL warm_armed[%0d] got=%b exp=%b", i, armed, s_tab[i] == 2'd2); end
    end
    step(64'd0, 64'd0);
    checks++; if (mis !== 1'b0) begin failures++; $display("[TB] FAIL warm_first_cmp got=%b exp=0", mis); end
  endtask

  task automatic test_alignment();
    logic [63:0] v_tab [6];
    v_tab = '{64'hA5, 64'h3C, 64'hFF, 64'h01, 64'h00, 64'h00};
    for (int i = 0; i < 6; i++) begin
      checks++; if (dly !== exp_dly_q[0]) begin failures++; $display("[TB] FAIL align_dly[%0d] got=%h exp=%h", i, dly, exp_dly_q[0]); end
      step(v_tab[i], 64'd0);
      checks++; if (mis !== 1'b0) begin failures++; $display("[TB] FAIL align_mis[%0d] got=%b exp=0", i, mis); end
    end
    checks++; if (err !== 16'd0) begin failures++; $display("[TB] FAIL align_err got=%0d exp=0", err); end
  endtask

  task automatic test_single_transient();
    step(64'h0F, 64'd0);
    step(64'h00, 64'd0);
    checks++; if (dly !== 64'h0F) begin failures++; $display("[TB] FAIL tr_dly got=%h exp=f", dly); end
    step(64'h00, 64'h01);
    checks++; if (mis !== 1'b1) begin failures++; $display("[TB] FAIL tr_mis got=%b exp=1", mis); end
    checks++; if (err !== 16'd1) begin failures++; $display("[TB] FAIL tr_err got=%0d exp=1", err); end
    checks++; if (syn !== 64'h01) begin failures++; $display("[TB] FAIL tr_syn got=%h exp=1", syn); end
    checks++; if (state !== 2'd2) begin failures++; $display("[TB] FAIL tr_state got=%0d exp=2", state); end
    step(64'h00, 64'd0);
    checks++; if ({mis, fault} !== 2'b00) begin failures++; $display("[TB] FAIL tr_after got=%b exp=00", {mis, fault}); end
    clear = 1'b1;
    step(64'h00, 64'd0);
    clear = 1'b0;
    checks++; if (syn !== 64'h01 || state !== 2'd2) begin failures++; $display("[TB] FAIL clr_ignored syn=%h state=%0d exp syn=1 state=2", syn, state); end
  endtask

  task automatic test_escalation();
    bring_up();
    step(64'h10, 64'd0);
    step(64'h20, 64'd0);
    step(64'h00, 64'h10);
    checks++; if (mis !== 1'b1 || state !== 2'd2) begin failures++; $display("[TB] FAIL esc1 mis=%b state=%0d exp mis=1 state=2", mis, state); end
    checks++; if (syn !== 64'h10) begin failures++; $display("[TB] FAIL esc1_syn got=%h exp=10", syn); end
    step(64'h00, 64'h20);
    checks++; if (state !== 2'd3) begin failures++; $display("[TB] FAIL esc2_state got=%0d exp=3", state); end
    checks++; if ({fault, armed, mis} !== 3'b101) begin failures++; $display("[TB] FAIL esc2_flags got=%b exp=101", {fault, armed, mis}); end
    checks++; if (err !== 16'd2) begin failures++; $display("[TB] FAIL esc2_err got=%0d exp=2", err); end
    checks++; if (syn !== 64'h10) begin failures++; $display("[TB] FAIL esc2_syn got=%h exp=10", syn); end
    step(64'h00, 64'hFF);
    checks++; if (mis !== 1'b0 || err !== 16'd2) begin failures++; $display("[TB] FAIL fault_suspend mis=%b err=%0d exp mis=0 err=2", mis, err); end
    enable = 1'b0;
    step(64'h00, 64'd0);
    enable = 1'b1;
    checks++; if (state !== 2'd3) begin failures++; $display("[TB] FAIL fault_en_ignored got=%0d exp=3", state); end
    clear = 1'b1;
    step(64'h00, 64'd0);
    clear = 1'b0;
    checks++; if (state !== 2'd1 || syn !== 64'd0) begin failures++; $display("[TB] FAIL clr state=%0d syn=%h exp state=1 syn=0", state, syn); end
    checks++; if (fault !== 1'b0 || err !== 16'd2) begin failures++; $display("[TB] FAIL clr_keep fault=%b err=%0d exp fault=0 err=2", fault, err); end
    step(64'h00, 64'd0);
    checks++; if (state !== 2'd1) begin failures++; $display("[TB] FAIL rewarm1 got=%0d exp=1", state); end
    step(64'h00, 64'd0);
    checks++; if (state !== 2'd2 || armed !== 1'b1) begin failures++; $display("[TB] FAIL rewarm2 state=%0d armed=%b exp 2/1", state, armed); end
  endtask

  task automatic test_priority();
    step(64'h00, 64'h03);
    checks++; if (err !== 16'd3 || syn !== 64'h03) begin failures++; $display("[TB] FAIL pri1 err=%0d syn=%h exp 3/3", err, syn); end
    enable = 1'b0;
    step(64'h00, 64'h04);
    checks++; if (state !== 2'd3 || fault !== 1'b1) begin failures++; $display("[TB] FAIL pri_fault state=%0d fault=%b exp 3/1", state, fault); end
    checks++; if (err !== 16'd4 || syn !== 64'h03) begin failures++; $display("[TB] FAIL pri2 err=%0d syn=%h exp 4/3", err, syn); end
    clear = 1'b1;
    step(64'h00, 64'd0);
    clear = 1'b0;
    checks++; if (state !== 2'd1) begin failures++; $display("[TB] FAIL pri_clr got=%0d exp=1", state); end
    step(64'h00, 64'd0);
    checks++; if (state !== 2'd0) begin failures++; $display("[TB] FAIL warm_abort got=%0d exp=0", state); end
  endtask

  task automatic test_enable_drop();
    enable = 1'b1;
    for (int i = 0; i < 3; i++) step(64'd0, 64'd0);
    step(64'h00, 64'h01);
    enable = 1'b0;
    step(64'h00, 64'd0);
    checks++; if (state !== 2'd0 || err !== 16'd5) begin failures++; $display("[TB] FAIL drop state=%0d err=%0d exp 0/5", state, err); end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) step(64'd0, 64'd0);
    step(64'h00, 64'h02);
    checks++; if (state !== 2'd2) begin failures++; $display("[TB] FAIL consec_cleared got=%0d exp=2", state); end
    checks++; if (err !== 16'd6 || syn !== 64'h01) begin failures++; $display("[TB] FAIL drop_keep err=%0d syn=%h exp 6/1", err, syn); end
    step(64'h00, 64'd0);
  endtask

  task automatic test_async_reset();
    step(64'hAB, 64'h05);
    step(64'hCD, 64'h06);
    checks++; if (state !== 2'd3 || err !== 16'd8) begin failures++; $display("[TB] FAIL pre_rst state=%0d err=%0d exp 3/8", state, err); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (fault !== 1'b0 || err !== 16'd0) begin failures++; $display("[TB] FAIL async fault=%b err=%0d exp 0/0", fault, err); end
    checks++; if (state !== 2'd0 || syn !== 64'd0 || dly !== 64'd0) begin failures++; $display("[TB] FAIL async_rest state=%0d syn=%h dly=%h exp 0", state, syn, dly); end
    tick();
    rst_n = 1'b1;
    enable = 1'b0;
    flush_model();
    step(64'd0, 64'd0);
    checks++; if (state !== 2'd0) begin failures++; $display("[TB] FAIL post_rst_idle got=%0d exp=0", state); end
    enable = 1'b1;
    step(64'd0, 64'd0);
    checks++; if (state !== 2'd1) begin failures++; $display("[TB] FAIL post_rst_warm got=%0d exp=1", state); end
  endtask

  task automatic test_saturation();
    logic [3:0] e;
    s_rst_n = 1'b1;
    s_enable = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (s_state !== 2'd2) begin failures++; $display("[TB] FAIL sat_armed got=%0d exp=2", s_state); end
    for (int k = 1; k <= 20; k++) begin
      s_shadow = 64'h1;
      exp_err_q.push_back((k > 15) ? 4'd15 : 4'(k));
      tick();
      e = exp_err_q.pop_front();
      checks++; if (s_err !== e || s_mis !== 1'b1) begin failures++; $display("[TB] FAIL sat_err[%0d] got=%0d mis=%b exp=%0d mis=1", k, s_err, s_mis, e); end
      s_shadow = 64'h0;
      tick();
      checks++; if (s_fault !== 1'b0 || s_mis !== 1'b0) begin failures++; $display("[TB] FAIL sat_nofault[%0d] fault=%b mis=%b exp 0/0", k, s_fault, s_mis); end
    end
    checks++; if (s_err !== 4'd15 || s_state !== 2'd2) begin failures++; $display("[TB] FAIL sat_final err=%0d state=%0d exp 15/2", s_err, s_state); end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clear = 1'b0; main_bus = '0; shadow_bus = '0;
    s_rst_n = 1'b0; s_enable = 1'b0; s_clear = 1'b0; s_main = '0; s_shadow = '0;
    test_reset();
    test_warmup();
    test_alignment();
    test_single_transient();
    test_escalation();
    test_priority();
    test_enable_drop();
    test_async_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/dcls_lockstep_ctrl.md
Name: dcls_lockstep_ctrl

Overview:
- Lockstep checker and sequencer for the dual-core lockstep pair.
- Delays the main core's output bundle by DCLS_DELAY cycles to align it with the shadow core, which receives its inputs through the input delay line. Then compares the two cores every cycle.
- Sequences warm-up after reset or enable, counts mismatches and escalates to a sticky fault.
- Sits beside the input delay line at the lockstep wrapper top level.

Parameters:
- DCLS_DELAY, 2, pipeline depth for the main core bundle; must equal the shadow input delay; legal range 1..15.
- CMP_W, 64, width of the compared core-output bundle.
- FAULT_THRESH, 2, number of consecutive mismatching cycles that escalates to FAULT; legal range 1..15.
- CNT_W, 16, width of the saturating total-mismatch counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- enable_i  in  1  comparison enable; while low, the block holds IDLE
- clear_i  in  1  single-cycle fault acknowledge; leaves FAULT and clears the syndrome
- main_bus_i  in  CMP_W  main core outputs, undelayed
- shadow_bus_i  in  CMP_W  shadow core outputs, already aligned by construction
- main_bus_dly_o  in→out  CMP_W  main bundle delayed by DCLS_DELAY (direction: out)
- armed_o  out  1  high in CHECK only
- mismatch_o  out  1  registered pulse, one cycle per mismatching compare
- fault_o  out  1  sticky, high in FAULT
- syndrome_o  out  CMP_W  XOR of the first mismatch since the last clear or reset
- err_cnt_o  out  CNT_W  total mismatch count, saturating
- state_o  out  2  encoding: IDLE=0, WARMUP=1, CHECK=2, FAULT=3

Behaviour:
- Reset (rst_ni low, asynchronous): state=IDLE; all delay stages, syndrome_o, err_cnt_o, the consecutive counter and the warm-up counter=0; armed_o, mismatch_o and fault_o=0.
- Delay line:
  - Shifts every cycle in all states.
  - main_bus_dly_o equals main_bus_i from exactly DCLS_DELAY cycles earlier.
  - Stage contents are 0 from reset until filled.
- Compare: miss = (main_bus_dly_o != shadow_bus_i). It is evaluated only in CHECK.
- IDLE:
  - enable_i=1 moves to WARMUP and loads warm=0.
- WARMUP:
  - warm increments each cycle.
  - When warm == DCLS_DELAY-1, moves to CHECK, so DCLS_DELAY cycles are spent in WARMUP.
  - No comparison takes place.
  - enable_i=0 returns to IDLE.
- CHECK:
  - On miss: next-cycle mismatch_o=1; err_cnt_o increments and saturates at all ones; consec increments.
  - The syndrome is captured (main XOR shadow) only when syndrome_o==0 and no capture has happened since the last clear.
  - If consec+1 == FAULT_THRESH, move to FAULT.
  - On no miss: consec=0.
  - enable_i=0 moves to IDLE and clears consec. err_cnt_o and syndrome_o are retained.
- FAULT:
  - fault_o=1; comparison is suspended; enable_i is ignored.
  - clear_i=1 moves to WARMUP and clears syndrome_o and consec. err_cnt_o is retained.
- Simultaneous events:
  - clear_i outside FAULT is ignored.
  - In CHECK, a miss that reaches the threshold in the same cycle enable_i falls goes to FAULT, because FAULT has priority over IDLE.
- Output registration: all outputs are registered. mismatch_o and the FAULT entry appear one cycle after the mismatching compare cycle.
- Reset mid-operation returns immediately to the reset values. Warm-up restarts after enable_i is seen post-reset.
- Width rules: err_cnt_o saturates at 2^CNT_W-1 and never wraps. Consec and warm are 4-bit.

Test Plan:
- Warm-up: enable_i=1 at cycle 0 with DCLS_DELAY=2 → state_o goes 1 at cycle 1 and 2 at cycle 3. armed_o=1 from cycle 3. A stimulus with unequal buses during WARMUP produces no mismatch_o.
- Alignment: main_bus_i=0xA5 at cycle N → main_bus_dly_o=0xA5 at cycle N+2. With shadow_bus_i=0xA5 at N+2, there is no mismatch and err_cnt_o stays 0.
- Single transient, FAULT_THRESH=2: one mismatching cycle with main=0x0F and shadow=0x0E → one mismatch_o pulse, err_cnt_o=1, syndrome_o=0x01, state stays CHECK.
- Escalation: two consecutive mismatches (0x10 vs 0x00, then 0x20 vs 0x00) → fault_o=1, state_o=3, err_cnt_o=2, syndrome_o=0x10. Then clear_i pulse → syndrome_o=0, state_o=1, and CHECK again after 2 cycles.
- Saturation, CNT_W=4, FAULT_THRESH=15: alternate miss and match for 20 compares → err_cnt_o=15 (no wrap), no fault.
- Async reset: assert rst_ni low mid-FAULT between clock edges → fault_o and err_cnt_o clear immediately, state_o=0.
